// File: rtl/qupls4_free_tag_queue_pkg.sv
// Shared CPU types for the free-tag queue slice: physical register tag type and queue sizing.
package qupls4_free_tag_queue_pkg;

    localparam int unsigned PREGS     = 512;
    localparam int unsigned PREG_W    = $clog2(PREGS);
    localparam int unsigned FTQ_DEPTH = 32;

    typedef logic [PREG_W-1:0] pregno_t;

endpackage

// File: rtl/qupls4_free_tag_queue_tag_compactor.sv
// Left-packs valid tags in slot order and reports how many were valid.
module qupls4_tag_compactor
    import qupls4_free_tag_queue_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  pregno_t                    tag_i [N],
    input  logic    [N-1:0]            v_i,
    output pregno_t                    tag_o [N],
    output logic    [$clog2(N+1)-1:0]  npush
);

    localparam int unsigned NW = $clog2(N + 1);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    logic [NW-1:0] pos;

    // Running prefix count gives each valid tag its packed destination slot.
    always_comb begin
        pos = '0;
        for (int i = 0; i < int'(N); i++) begin
            tag_o[i] = '0;
        end
        for (int i = 0; i < int'(N); i++) begin
            if (v_i[i]) begin
                tag_o[IW'(pos)] = tag_i[i];
                pos             = pos + NW'(1);
            end
        end
        npush = pos;
    end

endmodule

// File: rtl/qupls4_free_tag_queue.sv
// Buffers tags released at commit and drains up to NFTAGS per clock to the register name supplier.
module qupls4_free_tag_queue
    import qupls4_free_tag_queue_pkg::*;
#(
    parameter int unsigned NCMT      = 8,
    parameter int unsigned NFTAGS    = 4,
    parameter int unsigned DEPTH     = FTQ_DEPTH,
    parameter int unsigned SKIP_ZERO = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  pregno_t                   cmt_tag [NCMT],
    input  logic    [NCMT-1:0]        cmt_v,
    output pregno_t                   tags2free [NFTAGS],
    output logic    [NFTAGS-1:0]      freevals,
    output logic                      stall_cmt,
    output logic    [$clog2(DEPTH):0] count,
    output logic                      ovf
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned AW = CW + 1;
    localparam int unsigned NW = $clog2(NCMT + 1);

    pregno_t         mem_q [DEPTH];
    pregno_t         mem_d [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            stall_q, stall_d;
    logic            ovf_q, ovf_d;

    logic [NCMT-1:0] tag_ok;
    pregno_t         ctag [NCMT];
    logic [NW-1:0]   npush;
    logic [CW-1:0]   npop;
    logic [AW-1:0]   kept;
    logic [AW-1:0]   space;
    logic [AW-1:0]   nwrite;
    logic [AW-1:0]   next_cnt;
    logic            overflow_c;

    // Tag 0 is the hard-wired register and is never returned to the free pool.
    always_comb begin
        tag_ok = '0;
        for (int i = 0; i < int'(NCMT); i++) begin
            tag_ok[i] = cmt_v[i] && !((SKIP_ZERO != 0) && (cmt_tag[i] == '0));
        end
    end

    qupls4_tag_compactor #(
        .N (NCMT)
    ) u_compactor (
        .tag_i (cmt_tag),
        .v_i   (tag_ok),
        .tag_o (ctag),
        .npush (npush)
    );

    // Pop is decided from the registered count; pushes beyond free space are dropped.
    always_comb begin
        npop       = (count_q > CW'(NFTAGS)) ? CW'(NFTAGS) : count_q;
        kept       = AW'(count_q) - AW'(npop);
        space      = AW'(DEPTH) - kept;
        overflow_c = AW'(npush) > space;
        nwrite     = overflow_c ? space : AW'(npush);
        next_cnt   = kept + nwrite;
    end

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q + PW'(npop);
        wr_ptr_d = wr_ptr_q + PW'(nwrite);
        count_d  = CW'(next_cnt);
        stall_d  = next_cnt > AW'(DEPTH - NCMT);
        ovf_d    = ovf_q | overflow_c;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            stall_d  = 1'b0;
            ovf_d    = ovf_q;
        end else begin
            for (int k = 0; k < int'(NCMT); k++) begin
                if (AW'(k) < nwrite) begin
                    mem_d[wr_ptr_q + PW'(k)] = ctag[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            stall_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            stall_q  <= stall_d;
            ovf_q    <= ovf_d;
        end
    end

    // Output window: the oldest npop entries, zero elsewhere.
    always_comb begin
        for (int j = 0; j < int'(NFTAGS); j++) begin
            tags2free[j] = '0;
            freevals[j]  = 1'b0;
            if (CW'(j) < npop) begin
                tags2free[j] = mem_q[rd_ptr_q + PW'(j)];
                freevals[j]  = 1'b1;
            end
        end
    end

    assign stall_cmt = stall_q;
    assign count     = count_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_qupls4_free_tag_queue.sv
// Scoreboard bench for the free-tag queue: directed bursts, wrap streaming, clear and reset.
module tb_qupls4_free_tag_queue;
    import qupls4_free_tag_queue_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    pregno_t    cmt_tag [8];
    logic [7:0] cmt_v;
    pregno_t    tags2free [4];
    logic [3:0] freevals;
    logic       stall_cmt;
    logic [5:0] count;
    logic       ovf;

    qupls4_free_tag_queue dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .cmt_tag   (cmt_tag),
        .cmt_v     (cmt_v),
        .tags2free (tags2free),
        .freevals  (freevals),
        .stall_cmt (stall_cmt),
        .count     (count),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int      n_chk  = 0;
    int      n_pass = 0;
    pregno_t exp_q [$];
    pregno_t stim_tag [8];
    int      mcnt   = 0;
    bit      movf   = 1'b0;
    bit      mstall = 1'b0;
    int      tag_ctr = 16;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic pregno_t next_tag();
        tag_ctr = (tag_ctr + 1) % PREGS;
        if (tag_ctr == 0) tag_ctr = 1;
        return pregno_t'(tag_ctr);
    endfunction

    function automatic void fill_stim();
        for (int i = 0; i < 8; i++) stim_tag[i] = next_tag();
    endfunction

    // Monitor: every presented tag must be the next one the scoreboard expects.
    always @(negedge clk) begin
        if (!rst) begin
            n_chk++;
            if (freevals inside {4'h0, 4'h1, 4'h3, 4'h7, 4'hF}) n_pass++;
            else $display("FAIL freevals_contig: got %h", freevals);
            for (int j = 0; j < 4; j++) begin
                if (freevals[j]) begin
                    n_chk++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL tag_unexpected: slot %0d got %0d, queue empty", j, tags2free[j]);
                    end else begin
                        pregno_t e;
                        e = exp_q.pop_front();
                        if (tags2free[j] == e) n_pass++;
                        else $display("FAIL tag_order: slot %0d got %0d expected %0d", j, tags2free[j], e);
                    end
                end
            end
        end
    end

    // One clock: check registered state against the model, then drive and advance the model.
    task automatic step(input logic [7:0] v, input logic clr, input logic r);
        pregno_t vl [$];
        int npop, space, wr;
        bit flush;
        @(posedge clk);
        #1;
        chk("count", int'(count), mcnt);
        chk("stall_cmt", int'(stall_cmt), int'(mstall));
        chk("ovf", int'(ovf), int'(movf));
        cmt_v   = v;
        cmt_tag = stim_tag;
        clear   = clr;
        rst     = r;
        flush   = 1'b0;
        for (int i = 0; i < 8; i++) if (v[i] && stim_tag[i] != 0) vl.push_back(stim_tag[i]);
        npop  = (mcnt > 4) ? 4 : mcnt;
        space = 32 - (mcnt - npop);
        wr    = (vl.size() > space) ? space : vl.size();
        if (r) begin
            mcnt = 0; movf = 1'b0; mstall = 1'b0; flush = 1'b1;
        end else if (clr) begin
            mcnt = 0; mstall = 1'b0; flush = 1'b1;
        end else begin
            for (int k = 0; k < wr; k++) exp_q.push_back(vl[k]);
            if (vl.size() > space) movf = 1'b1;
            mcnt   = mcnt - npop + wr;
            mstall = (mcnt > 24);
        end
        if (flush) begin
            @(negedge clk);
            #1;
            exp_q.delete();
        end
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; cmt_v = '0;
        for (int i = 0; i < 8; i++) begin
            cmt_tag[i]  = '0;
            stim_tag[i] = '0;
        end
        repeat (2) step(8'h00, 1'b0, 1'b1);

        // Idle after reset
        repeat (3) begin
            step(8'h00, 1'b0, 1'b0);
            chk("idle_freevals", int'(freevals), 0);
            chk("idle_count", int'(count), 0);
            chk("idle_stall", int'(stall_cmt), 0);
        end

        // Four tags in, out next cycle
        for (int i = 0; i < 8; i++) stim_tag[i] = (i < 4) ? pregno_t'(10 + i) : '0;
        step(8'h0F, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        chk("t2_freevals", int'(freevals), 15);
        for (int j = 0; j < 4; j++) chk("t2_tag", int'(tags2free[j]), 10 + j);
        step(8'h00, 1'b0, 1'b0);
        chk("t2_freevals_drained", int'(freevals), 0);

        // Sparse mask with tag 0 in slot 0
        for (int i = 0; i < 8; i++) stim_tag[i] = pregno_t'(i);
        step(8'hA5, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        chk("t3_freevals", int'(freevals), 7);
        chk("t3_tag0", int'(tags2free[0]), 2);
        chk("t3_tag1", int'(tags2free[1]), 5);
        chk("t3_tag2", int'(tags2free[2]), 7);
        chk("t3_tag3", int'(tags2free[3]), 0);
        step(8'h00, 1'b0, 1'b0);

        // Full-width burst through stall into overflow
        fill_stim(); step(8'hFF, 1'b0, 1'b0);
        fill_stim(); step(8'hFF, 1'b0, 1'b0);
        chk("t4_count_c0", int'(count), 8);
        fill_stim(); step(8'hFF, 1'b0, 1'b0);
        chk("t4_count_c1", int'(count), 12);
        fill_stim(); step(8'hFF, 1'b0, 1'b0);
        chk("t4_count_c2", int'(count), 16);
        fill_stim(); step(8'hFF, 1'b0, 1'b0);
        chk("t4_count_c3", int'(count), 20);
        fill_stim(); step(8'hFF, 1'b0, 1'b0);
        chk("t4_count_c4", int'(count), 24);
        chk("t4_stall_at24", int'(stall_cmt), 0);
        fill_stim(); step(8'hFF, 1'b0, 1'b0);
        chk("t4_count_c5", int'(count), 28);
        chk("t4_stall_at28", int'(stall_cmt), 1);
        fill_stim(); step(8'hFF, 1'b0, 1'b0);
        chk("t4_count_c6", int'(count), 32);
        chk("t4_ovf_before", int'(ovf), 0);
        for (int i = 0; i < 8; i++) stim_tag[i] = '0;
        step(8'h00, 1'b0, 1'b0);
        chk("t4_count_c7", int'(count), 32);
        chk("t4_ovf_sticky", int'(ovf), 1);
        repeat (10) step(8'h00, 1'b0, 1'b0);
        chk("t4_drained", int'(count), 0);
        chk("t4_ovf_held", int'(ovf), 1);

        // 100 distinct tags under random masks, across pointer wrap
        begin
            int sent = 0;
            int guard = 0;
            while (sent < 100 && guard < 2000) begin
                logic [7:0] m;
                guard++;
                m = mstall ? 8'h00 : 8'($urandom_range(0, 255));
                for (int i = 0; i < 8; i++) begin
                    if (m[i] && sent < 100) begin
                        stim_tag[i] = next_tag();
                        sent++;
                    end else begin
                        m[i] = 1'b0;
                        stim_tag[i] = pregno_t'($urandom_range(0, 3));
                    end
                end
                step(m, 1'b0, 1'b0);
            end
            chk("t5_all_sent", sent, 100);
        end
        for (int i = 0; i < 8; i++) stim_tag[i] = '0;
        repeat (12) step(8'h00, 1'b0, 1'b0);
        chk("t5_count_zero", int'(count), 0);
        chk("t5_queue_empty", exp_q.size(), 0);

        // Clear with count 12 and a full push in the same cycle
        fill_stim(); step(8'hFF, 1'b0, 1'b0);
        fill_stim(); step(8'hFF, 1'b0, 1'b0);
        fill_stim(); step(8'hFF, 1'b1, 1'b0);
        chk("t6_clear_drain", int'(freevals), 15);
        for (int i = 0; i < 8; i++) stim_tag[i] = '0;
        step(8'h00, 1'b0, 1'b0);
        chk("t6_clear_count", int'(count), 0);
        chk("t6_clear_freevals", int'(freevals), 0);
        chk("t6_clear_ovf_kept", int'(ovf), 1);
        step(8'h00, 1'b0, 1'b0);

        // Same scenario with reset instead of clear
        fill_stim(); step(8'hFF, 1'b0, 1'b0);
        fill_stim(); step(8'hFF, 1'b0, 1'b0);
        fill_stim(); step(8'hFF, 1'b0, 1'b1);
        chk("t6_rst_drain", int'(freevals), 15);
        for (int i = 0; i < 8; i++) stim_tag[i] = '0;
        step(8'h00, 1'b0, 1'b0);
        chk("t6_rst_count", int'(count), 0);
        chk("t6_rst_freevals", int'(freevals), 0);
        chk("t6_rst_ovf", int'(ovf), 0);
        chk("t6_rst_stall", int'(stall_cmt), 0);
        repeat (2) step(8'h00, 1'b0, 1'b0);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
